// File: rtl/iter_divider_pkg.sv
// Shared execute-stage definitions used by the iterative divider.
package iter_divider_pkg;

    // Datapath width of the execute stage
    localparam int unsigned XLEN = 32;

    // MSB of an XLEN-bit word, i.e. the most-negative two's complement value
    localparam logic [XLEN-1:0] XLEN_MSB = {1'b1, {(XLEN-1){1'b0}}};

    // MIPS R-type funct codes served by the divider
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    // Divider sequencer states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/iter_divider_step.sv
// One combinational restoring division step on unsigned magnitudes.
module iter_divider_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           ge;

    // Shift {rem,q} left by one and conditionally subtract using a WIDTH+1 bit compare
    always_comb begin
        rem_sh = {rem_i, q_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr_i};
        ge     = (rem_sh >= {1'b0, dvsr_i});
        rem_o  = ge ? WIDTH'(diff) : WIDTH'(rem_sh);
        q_o    = {q_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU; quotient to LO, remainder to HI.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned     CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic [WIDTH-1:0] step_rem_d;
    logic [WIDTH-1:0] step_quo_d;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             dz_case;
    logic             ovf_case;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    iter_divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .q_i    (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem_d),
        .q_o    (step_quo_d)
    );

    // Operand magnitudes, special-case detection and final sign fix-up
    always_comb begin
        a_neg    = is_signed & dividend[WIDTH-1];
        b_neg    = is_signed & divisor[WIDTH-1];
        a_mag    = a_neg ? (~dividend + WIDTH'(1)) : dividend;
        b_mag    = b_neg ? (~divisor + WIDTH'(1)) : divisor;
        dz_case  = (divisor == '0);
        ovf_case = is_signed && (dividend == MSB) && (divisor == '1);
        quo_fix  = neg_quo_q ? (~step_quo_d + WIDTH'(1)) : step_quo_d;
        rem_fix  = neg_rem_q ? (~step_rem_d + WIDTH'(1)) : step_rem_d;
    end

    // Sequencer, iteration datapath and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (dz_case) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_q     <= DIV_FIN;
                        end else if (ovf_case) begin
                            quotient    <= MSB;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                            state_q     <= DIV_FIN;
                        end else begin
                            div_by_zero <= 1'b0;
                            rem_q       <= '0;
                            quo_q       <= a_mag;
                            dvsr_q      <= b_mag;
                            neg_quo_q   <= a_neg ^ b_neg;
                            neg_rem_q   <= a_neg;
                            cnt_q       <= CNT_W'(WIDTH - 1);
                            busy        <= 1'b1;
                            state_q     <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    rem_q <= step_rem_d;
                    quo_q <= step_quo_d;
                    if (cnt_q == '0) begin
                        quotient  <= quo_fix;
                        remainder <= rem_fix;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= DIV_FIN;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DIV_FIN: begin
                    done    <= 1'b0;
                    state_q <= DIV_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider (WIDTH = 32).
module tb_iter_divider;

    localparam int W       = 32;
    localparam int LAT_RUN = W + 1;
    localparam int BOUND   = 200;

    logic         clk;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total;
    int bad;

    iter_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        bit          edz;
        int          elat;
        int          ebusy;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic from the DIV/DIVU rules
    task automatic model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output bit dz,
                         output int lat, output int bsy);
        longint sa;
        longint sb;
        dz  = (b == 0);
        lat = LAT_RUN;
        bsy = W;
        if (b == 0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            lat = 1;
            bsy = 0;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            if (sa == -64'sd2147483648 && sb == -64'sd1) begin
                lat = 1;
                bsy = 0;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Pulse start in the next cycle, then wait (bounded) for done
    task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output bit dz,
                          output int lat, output int bsy);
        @(negedge clk);
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        lat = 0;
        bsy = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bsy++;
        end while (!done && lat < BOUND);
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
    endtask

    task automatic check_vs_model(input string tag, input bit sg, input logic [31:0] a,
                                  input logic [31:0] b);
        logic [31:0] q, r, eq, er;
        bit          dz, edz;
        int          lat, bsy, elat, ebsy;
        model(sg, a, b, eq, er, edz, elat, ebsy);
        run_op(sg, a, b, q, r, dz, lat, bsy);
        chk({tag, ".q"}, 64'(q), 64'(eq));
        chk({tag, ".r"}, 64'(r), 64'(er));
        chk({tag, ".dz"}, 64'(dz), 64'(edz));
        chk({tag, ".lat"}, 64'(lat), 64'(elat));
        chk({tag, ".busy"}, 64'(bsy), 64'(ebsy));
    endtask

    vec_t        vecs[7];
    logic [31:0] q, r, q0, r0;
    bit          dz;
    int          lat, bsy, n;
    logic [31:0] a, b;
    bit          sg;

    initial begin
        total = 0;
        bad   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vecs[0] = '{"divu_100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33, 32};
        vecs[1] = '{"div_m15_4",   1'b1, 32'hFFFF_FFF1, 32'd4,         32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 33, 32};
        vecs[2] = '{"div_15_m4",   1'b1, 32'd15,        32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'd3,         1'b0, 33, 32};
        vecs[3] = '{"div_dz",      1'b1, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1,  0};
        vecs[4] = '{"divu_dz",     1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1,  0};
        vecs[5] = '{"div_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1,  0};
        vecs[6] = '{"divu_msb",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33, 32};

        // Reset state
        #12;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.q", 64'(quotient), 64'd0);
        chk("rst.r", 64'(remainder), 64'd0);
        chk("rst.dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].sg, vecs[i].a, vecs[i].b, q, r, dz, lat, bsy);
            chk({vecs[i].name, ".q"}, 64'(q), 64'(vecs[i].eq));
            chk({vecs[i].name, ".r"}, 64'(r), 64'(vecs[i].er));
            chk({vecs[i].name, ".dz"}, 64'(dz), 64'(vecs[i].edz));
            chk({vecs[i].name, ".lat"}, 64'(lat), 64'(vecs[i].elat));
            chk({vecs[i].name, ".busy"}, 64'(bsy), 64'(vecs[i].ebusy));
        end

        // Outputs hold after done; dz flag clears at the next start, results do not
        run_op(1'b0, 32'h1234_5678, 32'd0, q, r, dz, lat, bsy);
        repeat (3) @(negedge clk);
        chk("hold.q", 64'(quotient), 64'hFFFF_FFFF);
        chk("hold.dz", 64'(div_by_zero), 64'd1);
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start.dz_clr", 64'(div_by_zero), 64'd0);
        chk("start.q_kept", 64'(quotient), 64'hFFFF_FFFF);
        chk("start.r_kept", 64'(remainder), 64'h1234_5678);
        chk("start.busy", 64'(busy), 64'd1);
        n = 1;
        while (!done && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("hold_op.lat", 64'(n), 64'(LAT_RUN));
        chk("hold_op.q", 64'(quotient), 64'd333);

        // Starts while running are ignored
        @(negedge clk);
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd7;
        start     = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = (n == 5 || n == 20);
            dividend  = (n == 5 || n == 20) ? 32'd999_999 : 32'd1000;
            divisor   = (n == 5 || n == 20) ? 32'd2 : 32'd7;
        end while (!done && n < BOUND);
        start = 1'b0;
        chk("ign.lat", 64'(n), 64'(LAT_RUN));
        chk("ign.q", 64'(quotient), 64'd142);
        chk("ign.r", 64'(remainder), 64'd6);
        // Back-to-back start in the cycle after done
        run_op(1'b1, 32'hFFFF_FF9C, 32'd9, q, r, dz, lat, bsy);
        chk("b2b.lat", 64'(lat), 64'(LAT_RUN));
        chk("b2b.q", 64'(q), 64'(32'hFFFF_FFF5));
        chk("b2b.r", 64'(r), 64'(32'hFFFF_FFFF));

        // Reset mid-operation aborts without done
        @(negedge clk);
        is_signed = 1'b0;
        dividend  = 32'd5000;
        divisor   = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.done", 64'(done), 64'd0);
        chk("arst.q", 64'(quotient), 64'd0);
        chk("arst.r", 64'(remainder), 64'd0);
        chk("arst.dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("arst.no_done", 64'(n), 64'd0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, q, r, dz, lat, bsy);
        chk("arst.next.q", 64'(q), 64'h0FFF_FFFF);
        chk("arst.next.r", 64'(r), 64'hF);
        chk("arst.next.lat", 64'(lat), 64'(LAT_RUN));

        // Randomized against the arithmetic reference
        for (int i = 0; i < 60; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                3: b = a;
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                5: b = ~a + 32'd1;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            check_vs_model($sformatf("rnd%0d", i), sg, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
